// File: rtl/hsi_pkg.sv
// Shared types for the hyperspectral pixel scheduler: FSM states and the
// job completion status reported back to the host.
package hsi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        FINISH    = 2'd3
    } sched_state_e;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        CORE_ERR = 2'd1,
        TIMEOUT  = 2'd2,
        ABORTED  = 2'd3
    } job_status_e;

endpackage

// File: rtl/hsi_watchdog.sv
// Per-pixel watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module hsi_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] count_q, count_d;
    logic          atLimit;

    assign atLimit   = (count_q == CW'(TIMEOUT_CYCLES - 1));
    assign expired_o = enable_i && atLimit;

    // Holding at the limit keeps the counter from wrapping if the owner lingers.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !atLimit) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hsi_pixel_scheduler.sv
// Job scheduler feeding a vector core one pixel at a time, with per-pixel
// timeout, abort handling and a registered completion report.
module hsi_pixel_scheduler
    import hsi_pkg::*;
#(
    parameter int OP_CODE_WIDTH   = 8,
    parameter int NUM_BANDS_WIDTH = 8,
    parameter int ERR_WIDTH       = 8,
    parameter int PIX_CNT_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [OP_CODE_WIDTH-1:0]   job_op_code_i,
    input  logic [NUM_BANDS_WIDTH-1:0] job_num_bands_i,
    input  logic [PIX_CNT_WIDTH-1:0]   job_num_pixels_i,
    input  logic                       abort_i,
    output logic [OP_CODE_WIDTH-1:0]   core_op_code_o,
    output logic [NUM_BANDS_WIDTH-1:0] core_num_bands_o,
    output logic                       core_start_o,
    input  logic                       core_pixel_done_i,
    input  logic [ERR_WIDTH-1:0]       core_error_code_i,
    output logic                       busy_o,
    output logic                       job_done_o,
    output logic [1:0]                 job_status_o,
    output logic [PIX_CNT_WIDTH-1:0]   pix_count_o,
    output logic [ERR_WIDTH-1:0]       first_err_o
);

    sched_state_e               state_q, state_d;
    job_status_e                status_q, status_d;
    logic [OP_CODE_WIDTH-1:0]   op_q, op_d;
    logic [NUM_BANDS_WIDTH-1:0] bands_q, bands_d;
    logic [PIX_CNT_WIDTH-1:0]   numPix_q, numPix_d;
    logic [PIX_CNT_WIDTH-1:0]   pixCount_q, pixCount_d;
    logic [PIX_CNT_WIDTH-1:0]   pixNext;
    logic [ERR_WIDTH-1:0]       firstErr_q, firstErr_d;
    logic                       jobDone_q, jobDone_d;
    logic                       wdExpired;

    hsi_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q == ISSUE),
        .enable_i (state_q == WAIT_DONE && !core_pixel_done_i),
        .expired_o(wdExpired)
    );

    assign pixNext = (pixCount_q == {PIX_CNT_WIDTH{1'b1}}) ? pixCount_q
                                                           : pixCount_q + 1'b1;

    // A finished pixel is counted before abort is considered; a core error outranks abort.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        op_d       = op_q;
        bands_d    = bands_q;
        numPix_d   = numPix_q;
        pixCount_d = pixCount_q;
        firstErr_d = firstErr_q;
        jobDone_d  = (state_q == FINISH);

        case (state_q)
            IDLE: begin
                if (job_valid_i) begin
                    op_d       = job_op_code_i;
                    bands_d    = job_num_bands_i;
                    numPix_d   = job_num_pixels_i;
                    pixCount_d = '0;
                    firstErr_d = '0;
                    status_d   = OK;
                    state_d    = (job_num_pixels_i == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    status_d = ABORTED;
                    state_d  = FINISH;
                end else begin
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_pixel_done_i) begin
                    pixCount_d = pixNext;
                    if (core_error_code_i != '0) begin
                        firstErr_d = core_error_code_i;
                        status_d   = CORE_ERR;
                        state_d    = FINISH;
                    end else if (abort_i) begin
                        status_d = ABORTED;
                        state_d  = FINISH;
                    end else if (pixNext == numPix_q) begin
                        status_d = OK;
                        state_d  = FINISH;
                    end else begin
                        state_d  = ISSUE;
                    end
                end else if (abort_i) begin
                    status_d = ABORTED;
                    state_d  = FINISH;
                end else if (wdExpired) begin
                    status_d = TIMEOUT;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            status_q   <= OK;
            op_q       <= '0;
            bands_q    <= '0;
            numPix_q   <= '0;
            pixCount_q <= '0;
            firstErr_q <= '0;
            jobDone_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            op_q       <= op_d;
            bands_q    <= bands_d;
            numPix_q   <= numPix_d;
            pixCount_q <= pixCount_d;
            firstErr_q <= firstErr_d;
            jobDone_q  <= jobDone_d;
        end
    end

    assign job_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign core_start_o     = (state_q == ISSUE);
    assign job_done_o       = jobDone_q;
    assign job_status_o     = status_q;
    assign pix_count_o      = pixCount_q;
    assign first_err_o      = firstErr_q;
    assign core_op_code_o   = op_q;
    assign core_num_bands_o = bands_q;

endmodule

// File: tb/tb_hsi_pixel_scheduler.sv
// Directed bench for hsi_pixel_scheduler: a bench-side core responder, a
// cycle model of the job rules checked every cycle, and per-job literals.
module tb_hsi_pixel_scheduler;

    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        job_valid_i;
    logic        job_ready_o;
    logic [7:0]  job_op_code_i;
    logic [7:0]  job_num_bands_i;
    logic [15:0] job_num_pixels_i;
    logic        abort_i;
    logic [7:0]  core_op_code_o;
    logic [7:0]  core_num_bands_o;
    logic        core_start_o;
    logic        core_pixel_done_i;
    logic [7:0]  core_error_code_i;
    logic        busy_o;
    logic        job_done_o;
    logic [1:0]  job_status_o;
    logic [15:0] pix_count_o;
    logic [7:0]  first_err_o;

    int tests = 0;
    int fails = 0;
    bit checkOn = 1'b0;

    int       respCnt = 0;
    int       pixIdx = 0;
    int       respDelay = 0;
    int       respErrPix = 0;
    int       respAbortPix = 0;
    logic [7:0] respErr = 8'h00;
    bit       respOn = 1'b0;
    int       startCount = 0;
    int       doneCount = 0;

    hsi_pixel_scheduler #(
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .job_valid_i      (job_valid_i),
        .job_ready_o      (job_ready_o),
        .job_op_code_i    (job_op_code_i),
        .job_num_bands_i  (job_num_bands_i),
        .job_num_pixels_i (job_num_pixels_i),
        .abort_i          (abort_i),
        .core_op_code_o   (core_op_code_o),
        .core_num_bands_o (core_num_bands_o),
        .core_start_o     (core_start_o),
        .core_pixel_done_i(core_pixel_done_i),
        .core_error_code_i(core_error_code_i),
        .busy_o           (busy_o),
        .job_done_o       (job_done_o),
        .job_status_o     (job_status_o),
        .pix_count_o      (pix_count_o),
        .first_err_o      (first_err_o)
    );

    always #5 clk = ~clk;

    // Reference behaviour: phase 0 idle, 1 issuing, 2 waiting on the core, 3 finishing.
    typedef struct packed {
        logic [1:0]  phase;
        logic [7:0]  op;
        logic [7:0]  bands;
        logic [15:0] total;
        logic [15:0] count;
        logic [1:0]  status;
        logic [7:0]  err;
        logic [7:0]  timer;
        logic        done;
    } model_t;

    model_t m = '0;

    function automatic model_t modelNext(input model_t c, input logic rst, input logic valid,
                                         input logic [7:0] op, input logic [7:0] bands,
                                         input logic [15:0] npix, input logic abort,
                                         input logic pdone, input logic [7:0] err);
        model_t n;
        n = c;
        if (rst) begin
            n = '0;
            return n;
        end
        n.done = (c.phase == 2'd3);
        case (c.phase)
            2'd0: if (valid) begin
                n.op     = op;
                n.bands  = bands;
                n.total  = npix;
                n.count  = 16'd0;
                n.err    = 8'd0;
                n.status = 2'd0;
                n.phase  = (npix == 16'd0) ? 2'd3 : 2'd1;
            end
            2'd1: begin
                n.timer = 8'd0;
                if (abort) begin
                    n.status = 2'd3;
                    n.phase  = 2'd3;
                end else begin
                    n.phase  = 2'd2;
                end
            end
            2'd2: begin
                if (pdone) begin
                    n.count = (c.count == 16'hFFFF) ? c.count : c.count + 16'd1;
                    if (err != 8'd0) begin
                        n.err = err; n.status = 2'd1; n.phase = 2'd3;
                    end else if (abort) begin
                        n.status = 2'd3; n.phase = 2'd3;
                    end else if (n.count == c.total) begin
                        n.status = 2'd0; n.phase = 2'd3;
                    end else begin
                        n.phase = 2'd1;
                    end
                end else if (abort) begin
                    n.status = 2'd3; n.phase = 2'd3;
                end else if (int'(c.timer) == TB_TIMEOUT - 1) begin
                    n.status = 2'd2; n.phase = 2'd3;
                end else begin
                    n.timer = c.timer + 8'd1;
                end
            end
            default: n.phase = 2'd0;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        m <= modelNext(m, rst_i, job_valid_i, job_op_code_i, job_num_bands_i, job_num_pixels_i,
                       abort_i, core_pixel_done_i, core_error_code_i);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("ready",     job_ready_o,      m.phase == 2'd0);
            checkOutput("busy",      busy_o,           m.phase != 2'd0);
            checkOutput("start",     core_start_o,     m.phase == 2'd1);
            checkOutput("done",      job_done_o,       m.done);
            checkOutput("status",    job_status_o,     m.status);
            checkOutput("pixCount",  pix_count_o,      m.count);
            checkOutput("firstErr",  first_err_o,      m.err);
            checkOutput("coreOp",    core_op_code_o,   m.op);
            checkOutput("coreBands", core_num_bands_o, m.bands);
        end
    end

    // One clock: inputs return to idle, then the core responder reacts to the new outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        job_valid_i       = 1'b0;
        core_pixel_done_i = 1'b0;
        core_error_code_i = 8'h00;
        abort_i           = 1'b0;
        if (respCnt > 0) begin
            respCnt--;
            if (respCnt == 0) begin
                pixIdx++;
                core_pixel_done_i = 1'b1;
                if (pixIdx == respErrPix) core_error_code_i = respErr;
                if (pixIdx == respAbortPix) abort_i = 1'b1;
            end
        end
        if (core_start_o) begin
            startCount++;
            if (respOn) respCnt = respDelay;
        end
        if (job_done_o) doneCount++;
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [7:0] bands, input logic [15:0] npix,
                                 input int delay, input int errPix, input logic [7:0] errCode,
                                 input int abortPix, input bit on,
                                 output int starts, output int dones, output int latency);
        respOn = on; respDelay = delay; respErrPix = errPix; respErr = errCode;
        respAbortPix = abortPix; pixIdx = 0; respCnt = 0;
        tick();
        checkOutput("readyAtAccept", job_ready_o, 1);
        job_valid_i      = 1'b1;
        job_op_code_i    = op;
        job_num_bands_i  = bands;
        job_num_pixels_i = npix;
        startCount = 0;
        doneCount  = 0;
        latency    = -1;
        for (int c = 1; c <= 200 && !(latency >= 0 && c > latency + 3); c++) begin
            tick();
            if (job_done_o && latency < 0) latency = c;
        end
        starts = startCount;
        dones  = doneCount;
        checkOutput("jobDoneSeen", latency >= 0, 1);
    endtask

    task automatic checkJob(input string tag, input int starts, input int dones, input int latency,
                            input int expStarts, input int expLatency, input logic [1:0] expStatus,
                            input logic [15:0] expPix, input logic [7:0] expErr, input logic [7:0] expOp);
        checkOutput({tag, ".starts"},      starts,         expStarts);
        checkOutput({tag, ".dones"},       dones,          1);
        checkOutput({tag, ".latency"},     latency,        expLatency);
        checkOutput({tag, ".status"},      job_status_o,   expStatus);
        checkOutput({tag, ".pixCount"},    pix_count_o,    expPix);
        checkOutput({tag, ".firstErr"},    first_err_o,    expErr);
        checkOutput({tag, ".coreOp"},      core_op_code_o, expOp);
        checkOutput({tag, ".modelStatus"}, m.status,       expStatus);
        checkOutput({tag, ".modelCount"},  m.count,        expPix);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int st, dn, lat;
        rst_i = 1'b1;
        job_valid_i = 1'b0; job_op_code_i = 8'h00; job_num_bands_i = 8'h00;
        job_num_pixels_i = 16'h0000; abort_i = 1'b0;
        core_pixel_done_i = 1'b0; core_error_code_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        checkOutput("rst.ready",    job_ready_o,  1);
        checkOutput("rst.busy",     busy_o,       0);
        checkOutput("rst.start",    core_start_o, 0);
        checkOutput("rst.status",   job_status_o, 0);
        checkOutput("rst.pixCount", pix_count_o,  0);
        checkOutput("rst.firstErr", first_err_o,  0);
        checkOn = 1'b1;

        applyStimulus(8'h01, 8'd4, 16'd3, 5, 0, 8'h00, 0, 1'b1, st, dn, lat);
        checkJob("normal", st, dn, lat, 3, 20, 2'd0, 16'd3, 8'h00, 8'h01);

        applyStimulus(8'h10, 8'd2, 16'd0, 5, 0, 8'h00, 0, 1'b1, st, dn, lat);
        checkJob("zeroPix", st, dn, lat, 0, 2, 2'd0, 16'd0, 8'h00, 8'h10);

        applyStimulus(8'h02, 8'd8, 16'd5, 5, 2, 8'h07, 0, 1'b1, st, dn, lat);
        checkJob("coreErr", st, dn, lat, 2, 14, 2'd1, 16'd2, 8'h07, 8'h02);

        applyStimulus(8'h03, 8'd1, 16'd2, 5, 0, 8'h00, 0, 1'b0, st, dn, lat);
        checkJob("timeout", st, dn, lat, 1, 19, 2'd2, 16'd0, 8'h00, 8'h03);

        applyStimulus(8'h04, 8'd16, 16'd4, 5, 0, 8'h00, 1, 1'b1, st, dn, lat);
        checkJob("abortDone", st, dn, lat, 1, 8, 2'd3, 16'd1, 8'h00, 8'h04);

        applyStimulus(8'h05, 8'd3, 16'd3, 2, 1, 8'h5A, 1, 1'b1, st, dn, lat);
        checkJob("errBeatsAbort", st, dn, lat, 1, 5, 2'd1, 16'd1, 8'h5A, 8'h05);

        respOn = 1'b1; respDelay = 3; respErrPix = 0; respAbortPix = 0; pixIdx = 0; respCnt = 0;
        tick();
        job_valid_i = 1'b1; job_op_code_i = 8'h22; job_num_bands_i = 8'd9; job_num_pixels_i = 16'd4;
        repeat (6) tick();
        checkOutput("midJob.busy",     busy_o,      1);
        checkOutput("midJob.pixCount", pix_count_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        startCount = 0;
        doneCount  = 0;
        checkOutput("midRst.ready",     job_ready_o,      1);
        checkOutput("midRst.busy",      busy_o,           0);
        checkOutput("midRst.start",     core_start_o,     0);
        checkOutput("midRst.done",      job_done_o,       0);
        checkOutput("midRst.status",    job_status_o,     0);
        checkOutput("midRst.pixCount",  pix_count_o,      0);
        checkOutput("midRst.firstErr",  first_err_o,      0);
        checkOutput("midRst.coreOp",    core_op_code_o,   0);
        checkOutput("midRst.coreBands", core_num_bands_o, 0);
        repeat (5) tick();
        checkOutput("midRst.noDone",  doneCount,  0);
        checkOutput("midRst.noStart", startCount, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
